// File: rtl/pipe_scheduler_if.sv
// Handshake and data bundle between the Flappy pipe scheduler and its game-side peers.
// The scheduler takes the slave view; the game controller / checker side takes master.
interface pipe_scheduler_if;
   logic        Start;
   logic        Ack;
   logic        Lose;
   logic        Frame_Tick;
   logic [9:0]  Bird_X_L;

   logic [9:0]  X_Edge_Left;
   logic [9:0]  X_Edge_Right;
   logic [9:0]  Y_Edge_Top;
   logic [9:0]  Y_Edge_Bottom;
   logic [43:0] Pipe_R_All;
   logic [39:0] Pipe_G_All;
   logic [1:0]  Cur_Pipe;
   logic [9:0]  Score;
   logic        Q_Idle;
   logic        Q_Run;
   logic        Q_Freeze;

   modport master (
      output Start, Ack, Lose, Frame_Tick, Bird_X_L,
      input  X_Edge_Left, X_Edge_Right, Y_Edge_Top, Y_Edge_Bottom,
             Pipe_R_All, Pipe_G_All, Cur_Pipe, Score, Q_Idle, Q_Run, Q_Freeze
   );

   modport slave (
      input  Start, Ack, Lose, Frame_Tick, Bird_X_L,
      output X_Edge_Left, X_Edge_Right, Y_Edge_Top, Y_Edge_Bottom,
             Pipe_R_All, Pipe_G_All, Cur_Pipe, Score, Q_Idle, Q_Run, Q_Freeze
   );
endinterface

// File: rtl/pipe_scheduler.sv
// Scrolling pipe field for Flappy: scrolls/recycles four pipes, picks the pipe in
// scope for the collision checker, counts score and freezes on a reported loss.
module pipe_scheduler #(
   parameter int unsigned PIPE_W   = 60,
   parameter int unsigned GAP_H    = 120,
   parameter int unsigned SPACING  = 160,
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SPEED    = 2,
   parameter int unsigned GAP_MIN  = 40,
   parameter int unsigned INIT_GAP = 180
) (
   input  logic            Clk,
   input  logic            reset,
   pipe_scheduler_if.slave bus
);

   localparam int unsigned N_PIPES   = 4;
   localparam logic [10:0] PIPE_W_X  = 11'(PIPE_W);
   localparam logic [10:0] SPEED_X   = 11'(SPEED);
   localparam logic [10:0] WRAP_X    = 11'(N_PIPES * SPACING);
   localparam logic [10:0] X_MAX     = 11'd1023;
   localparam logic [9:0]  GAP_H_Y   = 10'(GAP_H);
   localparam logic [9:0]  GAP_MIN_Y = 10'(GAP_MIN);
   localparam logic [9:0]  INIT_G_Y  = 10'(INIT_GAP);
   localparam logic [9:0]  SCORE_MAX = 10'd999;
   localparam logic [7:0]  LFSR_SEED = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'b001,
      S_RUN    = 3'b010,
      S_FREEZE = 3'b100
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        do_init;
   logic        do_scroll;
   logic        do_pass;
   logic        passing;

   logic [10:0] pipe_r [N_PIPES];
   logic [9:0]  pipe_g [N_PIPES];
   logic [1:0]  cur;
   logic [9:0]  score;
   logic [7:0]  lfsr;
   logic        lfsr_fb;

   logic [10:0] sel_r;
   logic [9:0]  sel_g;
   logic [10:0] left_x;
   logic [43:0] r_all;
   logic [39:0] g_all;

   function automatic logic [10:0] init_r(input int unsigned idx);
      return 11'(SCREEN_W + PIPE_W + idx * SPACING);
   endfunction

   // Pass test uses the registered right edge, so it lags a scroll by one clock.
   assign passing = ({1'b0, bus.Bird_X_L} > pipe_r[cur]);

   always_ff @(posedge Clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      do_init    = 1'b0;
      do_scroll  = 1'b0;
      do_pass    = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.Start) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            // A loss outranks a coincident frame tick: nothing moves on that edge.
            if (bus.Lose) begin
               state_next = S_FREEZE;
            end else begin
               do_scroll = bus.Frame_Tick;
               do_pass   = passing;
            end
         end
         S_FREEZE: begin
            if (bus.Ack) begin
               state_next = S_IDLE;
               do_init    = 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
            do_init    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset || do_init) begin
         for (int unsigned i = 0; i < N_PIPES; i++) begin
            pipe_r[i] <= init_r(i);
            pipe_g[i] <= INIT_G_Y;
         end
         cur   <= '0;
         score <= '0;
      end else begin
         if (do_scroll) begin
            for (int unsigned i = 0; i < N_PIPES; i++) begin
               if (pipe_r[i] <= SPEED_X) begin
                  pipe_r[i] <= pipe_r[i] - SPEED_X + WRAP_X;
                  pipe_g[i] <= GAP_MIN_Y + {3'b000, lfsr[7:1]};
               end else begin
                  pipe_r[i] <= pipe_r[i] - SPEED_X;
               end
            end
         end
         if (do_pass) begin
            cur <= cur + 2'd1;
            if (score < SCORE_MAX) begin
               score <= score + 10'd1;
            end
         end
      end
   end

   // LFSR survives the Ack re-initialisation so successive games get fresh gaps.
   assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   always_ff @(posedge Clk) begin
      if (reset) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[6:0], lfsr_fb};
      end
   end

   always_comb begin
      sel_r  = pipe_r[cur];
      sel_g  = pipe_g[cur];
      left_x = sel_r - PIPE_W_X;
   end

   always_comb begin
      r_all = '0;
      g_all = '0;
      for (int unsigned i = 0; i < N_PIPES; i++) begin
         r_all[11*i +: 11] = pipe_r[i];
         g_all[10*i +: 10] = pipe_g[i];
      end
   end

   assign bus.X_Edge_Right  = (sel_r > X_MAX) ? 10'd1023 : sel_r[9:0];
   assign bus.X_Edge_Left   = (sel_r > PIPE_W_X)
                              ? ((left_x > X_MAX) ? 10'd1023 : left_x[9:0])
                              : '0;
   assign bus.Y_Edge_Top    = sel_g;
   assign bus.Y_Edge_Bottom = sel_g + GAP_H_Y;
   assign bus.Pipe_R_All    = r_all;
   assign bus.Pipe_G_All    = g_all;
   assign bus.Cur_Pipe      = cur;
   assign bus.Score         = score;
   assign bus.Q_Idle        = state[0];
   assign bus.Q_Run         = state[1];
   assign bus.Q_Freeze      = state[2];

endmodule
